decode_queue: RTL and testbench

- Registered, flow-controlled successor of the combinational decode stage.
- Decodes one RV32 instruction per cycle into control signals, ALU op, immediate and register specifiers, then pushes the result into a parametrised-depth output queue.
- Uses valid/ready handshakes on both sides, a flush for mispredict/exception recovery, and an illegal-instruction flag instead of simulation-only messages.
- Sits between fetch and rename/dispatch.

---
 rtl/decode_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_decode_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32 decode stage feeding a DEPTH-entry valid/ready queue between fetch and rename.
// Each entry holds the PC, decoded control fields and an illegal flag; outputs read 0 while empty.
module decode_queue #(
  parameter int PC_WIDTH  = 12,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [6:0]           out_c_sig,
  output logic [2:0]           out_alu_sig,
  output logic [31:0]          out_imm,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SRL = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [6:0]          c_sig;
    logic [2:0]          alu;
    logic [31:0]         imm;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                illegal;
  } entry_t;

  // ---------------- decode ----------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {{12{in_instr[31]}}, in_instr[31:12]};

  logic        dec_legal;
  logic [6:0]  dec_c_sig;
  logic [2:0]  dec_alu;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  entry_t      dec_entry;

  always_comb begin
    dec_legal = 1'b0;
    dec_c_sig = '0;
    dec_alu   = ALU_ADD;
    dec_imm   = '0;
    dec_rd    = in_instr[11:7];
    dec_rs1   = in_instr[19:15];
    dec_rs2   = in_instr[24:20];
    case (opcode)
      OP_R: begin
        dec_c_sig = 7'b1000000;
        case (funct3)
          3'b000: begin dec_alu = ALU_ADD; dec_legal = 1'b1; end
          3'b100: begin dec_alu = ALU_XOR; dec_legal = 1'b1; end
          3'b101: begin dec_alu = ALU_SRL; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_I: begin
        dec_c_sig = 7'b1100000;
        dec_imm   = imm_i;
        dec_rs2   = '0;
        case (funct3)
          3'b000: begin dec_alu = ALU_ADD; dec_legal = 1'b1; end
          3'b110: begin dec_alu = ALU_OR;  dec_legal = 1'b1; end
          3'b101: begin dec_alu = ALU_SRL; dec_legal = 1'b1; end
          3'b111: begin dec_alu = ALU_AND; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_LOAD: begin
        dec_imm = imm_i;
        dec_rs2 = '0;
        case (funct3)
          3'b000: begin dec_c_sig = 7'b1101011; dec_legal = 1'b1; end
          3'b010: begin dec_c_sig = 7'b1101010; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_STORE: begin
        dec_imm = imm_s;
        dec_rd  = '0;
        case (funct3)
          3'b000: begin dec_c_sig = 7'b0100101; dec_legal = 1'b1; end
          3'b010: begin dec_c_sig = 7'b0100100; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_LUI: begin
        dec_c_sig = 7'b1100000;
        dec_alu   = ALU_SLL;
        dec_imm   = imm_u;
        dec_rs1   = '0;
        dec_rs2   = '0;
        dec_legal = 1'b1;
      end
      default: ;
    endcase
  end

  // Unsupported instructions keep only their PC so the consumer can raise the trap.
  always_comb begin
    dec_entry    = '0;
    dec_entry.pc = in_pc;
    if (dec_legal) begin
      dec_entry.c_sig = dec_c_sig;
      dec_entry.alu   = dec_alu;
      dec_entry.imm   = dec_imm;
      dec_entry.rd    = dec_rd;
      dec_entry.rs1   = dec_rs1;
      dec_entry.rs2   = dec_rs2;
    end else begin
      dec_entry.illegal = 1'b1;
    end
  end

  // ---------------- queue ----------------
  logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic                 push;
  logic                 pop;
  logic [DEPTH-1:0]     wr_en;
  entry_t               mem [DEPTH];
  entry_t               head;

  // Ready depends only on occupancy, so a full queue never accepts a push-through.
  assign in_ready  = (count_reg < DEPTH_CNT);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_WIDTH'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(1);
      if (push && !pop)      count_next = count_reg + CNT_WIDTH'(1);
      else if (pop && !push) count_next = count_reg - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PTR_WIDTH'(gi));
  end

  // Storage is never cleared; emptiness masks stale contents at the output.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem[i] <= dec_entry;
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr_reg];
  end

  assign out_pc      = head.pc;
  assign out_c_sig   = head.c_sig;
  assign out_alu_sig = head.alu;
  assign out_imm     = head.imm;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus randomized traffic checked against
// a queue-of-decoded-entries reference model.
module tb_decode_queue;
  localparam int PCW   = 12;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int EW    = PCW + 7 + 3 + 32 + 15 + 1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [PCW-1:0]  in_pc;
  logic [31:0]     in_instr;
  logic            in_ready, out_valid, out_illegal;
  logic [PCW-1:0]  out_pc;
  logic [6:0]      out_c_sig;
  logic [2:0]      out_alu_sig;
  logic [31:0]     out_imm;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [CW-1:0]   count;

  int compared   = 0;
  int mismatched = 0;
  logic [EW-1:0] model_q[$];

  always #5 clk = ~clk;

  decode_queue #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_c_sig(out_c_sig), .out_alu_sig(out_alu_sig), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_illegal(out_illegal), .count(count)
  );

  wire [EW-1:0] obs = {out_pc, out_c_sig, out_alu_sig, out_imm, out_rd, out_rs1, out_rs2, out_illegal};

  // Reference decode straight from the instruction-set rules.
  function automatic logic [EW-1:0] ref_decode(input logic [PCW-1:0] pc, input logic [31:0] i);
    logic [2:0] f3;
    logic [6:0] c;
    logic [2:0] a;
    logic [31:0] imm;
    logic [4:0] rd, rs1, rs2;
    logic ok;
    f3 = i[14:12];
    ok = 0; c = 0; a = 0; imm = 0;
    rd = i[11:7]; rs1 = i[19:15]; rs2 = i[24:20];
    case (i[6:0])
      7'h33: begin
        c = 7'b1000000;
        ok = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd5);
        a = (f3 == 3'd4) ? 3'd3 : (f3 == 3'd5) ? 3'd2 : 3'd0;
      end
      7'h13: begin
        c = 7'b1100000; imm = {{20{i[31]}}, i[31:20]}; rs2 = 0;
        ok = (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd5) || (f3 == 3'd7);
        a = (f3 == 3'd6) ? 3'd4 : (f3 == 3'd5) ? 3'd2 : (f3 == 3'd7) ? 3'd5 : 3'd0;
      end
      7'h03: begin
        ok = (f3 == 3'd0) || (f3 == 3'd2);
        c = (f3 == 3'd0) ? 7'b1101011 : 7'b1101010;
        imm = {{20{i[31]}}, i[31:20]}; rs2 = 0;
      end
      7'h23: begin
        ok = (f3 == 3'd0) || (f3 == 3'd2);
        c = (f3 == 3'd0) ? 7'b0100101 : 7'b0100100;
        imm = {{20{i[31]}}, i[31:25], i[11:7]}; rd = 0;
      end
      7'h37: begin
        ok = 1; c = 7'b1100000; a = 3'd1; imm = {{12{i[31]}}, i[31:12]}; rs1 = 0; rs2 = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) return {pc, 7'd0, 3'd0, 32'd0, 15'd0, 1'b1};
    return {pc, c, a, imm, rd, rs1, rs2, 1'b0};
  endfunction

  function automatic logic [EW-1:0] exp_head();
    if (model_q.size() == 0) return '0;
    return model_q[0];
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0] ops [6];
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h37;
    ops[5] = 7'($urandom);
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 5)];
    return r;
  endfunction

  // One clock: drive inputs, advance the model by the handshake rules, settle at negedge.
  task automatic step(input logic v, input logic [PCW-1:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl = 1'b0, input logic rs = 1'b0);
    bit do_push, do_pop;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl; rst = rs;
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = rdy && (model_q.size() > 0);
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
      $display("clear rst=%0b flush=%0b", rs, fl);
    end else begin
      if (do_pop) begin
        $display("pop  pc=%h", model_q[0][EW-1 -: PCW]);
        void'(model_q.pop_front());
      end
      if (do_push) begin
        model_q.push_back(ref_decode(pc, ins));
        $display("push pc=%h instr=%h", pc, ins);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    compared++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_flags: got count=%0d ov=%0b ir=%0b want 0 0 1", count, out_valid, in_ready);
    end
    compared++;
    if (obs !== '0) begin
      mismatched++;
      $display("FAIL reset_fields: got %h want 0", obs);
    end
  endtask

  task automatic test_first_push();
    step(1, 12'h010, 32'h002081B3, 0);
    compared++;
    if ({out_valid, out_c_sig, out_alu_sig, out_rd, out_rs1, out_rs2, out_imm, out_pc, count} !==
        {1'b1, 7'b1000000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 12'h010, 3'd1}) begin
      mismatched++;
      $display("FAIL add_fields: got ov=%0b c=%b alu=%b rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h cnt=%0d",
               out_valid, out_c_sig, out_alu_sig, out_rd, out_rs1, out_rs2, out_imm, out_pc, count);
    end
    step(0, 0, 0, 1);
    compared++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL add_drain: got count=%0d ov=%0b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [EW-1:0] want [4];
    ins[0] = 32'hFFF00293; ins[1] = 32'h00812303; ins[2] = 32'hFE612E23; ins[3] = 32'h123453B7;
    want[0] = {12'h020, 7'b1100000, 3'd0, 32'hFFFFFFFF, 5'd5, 5'd0, 5'd0, 1'b0};
    want[1] = {12'h024, 7'b1101010, 3'd0, 32'h00000008, 5'd6, 5'd2, 5'd0, 1'b0};
    want[2] = {12'h028, 7'b0100100, 3'd0, 32'hFFFFFFFC, 5'd0, 5'd2, 5'd6, 1'b0};
    want[3] = {12'h02C, 7'b1100000, 3'd1, 32'h00012345, 5'd7, 5'd0, 5'd0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      step(1, 12'(12'h020 + 4 * k), ins[k], 1);
      compared++;
      if (obs !== want[k] || count !== 3'd1) begin
        mismatched++;
        $display("FAIL b2b_%0d: got %h cnt=%0d want %h cnt=1", k, obs, count, want[k]);
      end
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_fill_wrap();
    for (int k = 0; k < DEPTH; k++) step(1, 12'(12'h100 + k), gen_instr(), 0);
    compared++;
    if (count !== 3'd4 || in_ready !== 1'b0 || obs !== exp_head()) begin
      mismatched++;
      $display("FAIL fill: got cnt=%0d ir=%0b head=%h want 4 0 %h", count, in_ready, obs, exp_head());
    end
    step(1, 12'h1FF, gen_instr(), 0);
    compared++;
    if (count !== 3'd4 || obs !== exp_head()) begin
      mismatched++;
      $display("FAIL full_reject: got cnt=%0d head=%h want 4 %h", count, obs, exp_head());
    end
    for (int k = 0; k < 14; k++) begin
      step(1, 12'(12'h200 + k), gen_instr(), 1);
      compared++;
      if (obs !== exp_head() || count !== CW'(model_q.size()) || in_ready !== (model_q.size() < DEPTH)) begin
        mismatched++;
        $display("FAIL wrap_%0d: got %h cnt=%0d ir=%0b want %h cnt=%0d", k, obs, count, in_ready,
                 exp_head(), model_q.size());
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, 0, 1);
      compared++;
      if (obs !== exp_head() || count !== CW'(model_q.size())) begin
        mismatched++;
        $display("FAIL drain_%0d: got %h cnt=%0d want %h cnt=%0d", k, obs, count, exp_head(), model_q.size());
      end
    end
  endtask

  task automatic test_illegal();
    step(1, 12'h2A0, 32'h0000006F, 0);
    step(1, 12'h2A4, 32'h0020F1B3, 0);
    compared++;
    if (obs !== {12'h2A0, 7'd0, 3'd0, 32'd0, 15'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL illegal_jal: got %h want pc 2a0 illegal only", obs);
    end
    step(0, 0, 0, 1);
    compared++;
    if (obs !== {12'h2A4, 7'd0, 3'd0, 32'd0, 15'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL illegal_rf3: got %h want pc 2a4 illegal only", obs);
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) step(1, 12'(12'h300 + k), gen_instr(), 0);
    compared++;
    if (count !== 3'd3) begin
      mismatched++;
      $display("FAIL flush_pre: got cnt=%0d want 3", count);
    end
    step(1, 12'h3AA, 32'h002081B3, 1, 1);
    compared++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      mismatched++;
      $display("FAIL flush: got cnt=%0d ov=%0b ir=%0b head=%h want 0 0 1 0", count, out_valid, in_ready, obs);
    end
    step(1, 12'h3BB, 32'h123453B7, 0);
    compared++;
    if (count !== 3'd1 || obs !== exp_head()) begin
      mismatched++;
      $display("FAIL flush_after: got cnt=%0d head=%h want 1 %h", count, obs, exp_head());
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_rst_full();
    for (int k = 0; k < DEPTH; k++) step(1, 12'(12'h400 + k), gen_instr(), 0);
    compared++;
    if (count !== 3'd4) begin
      mismatched++;
      $display("FAIL rst_pre: got cnt=%0d want 4", count);
    end
    step(1, 12'h4AA, gen_instr(), 1, 0, 1);
    compared++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      mismatched++;
      $display("FAIL rst_full: got cnt=%0d ov=%0b ir=%0b head=%h want 0 0 1 0", count, out_valid, in_ready, obs);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 12'($urandom), gen_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0);
      compared++;
      if (obs !== exp_head() || count !== CW'(model_q.size()) || in_ready !== (model_q.size() < DEPTH) ||
          out_valid !== (model_q.size() != 0)) begin
        mismatched++;
        $display("FAIL rand_%0d: got %h cnt=%0d ir=%0b want %h cnt=%0d", k, obs, count, in_ready,
                 exp_head(), model_q.size());
      end
    end
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_instr = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_first_push();
    test_back_to_back();
    test_fill_wrap();
    test_illegal();
    test_flush();
    test_rst_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
